// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: decode-stage RAW hazard unit with a per-register countdown scoreboard,
// branch flush and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int ALU_STALL = 2,
  parameter int LOAD_STALL = 2,
  parameter int CNT_W = 16,
  parameter logic [31:0] NOP_INS = 32'h13
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] ins_in,
  input  logic ins_valid,
  input  logic flush,
  output logic [31:0] ins_out,
  output logic ins_out_valid,
  output logic stall,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int MAX_S = ALU_STALL > LOAD_STALL ? ALU_STALL : LOAD_STALL;
  localparam int SW = MAX_S > 0 ? $clog2(MAX_S + 1) : 1;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic uses_rs1, uses_rs2, writes_rd, is_load, hazard, issue;
  logic [SW-1:0] cnt [32];
  assign op = ins_in[6:0];
  assign rd = ins_in[11:7];
  assign rs1 = ins_in[19:15];
  assign rs2 = ins_in[24:20];
  always_comb begin
    uses_rs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    uses_rs2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    writes_rd = !(op == 7'b0100011 || op == 7'b1100011) && rd != '0;
    is_load = op == 7'b0000011;
    hazard = ins_valid && ((uses_rs1 && rs1 != '0 && cnt[rs1] != '0) ||
                           (uses_rs2 && rs2 != '0 && cnt[rs2] != '0));
    stall = hazard && !flush && !reset;
    issue = ins_valid && !hazard && !flush && !reset;
    ins_out = issue ? ins_in : NOP_INS;
    ins_out_valid = issue;
  end
  // x0 and registers beyond NUM_REGS stay permanently clear
  always_ff @(posedge clk)
    for (int r = 0; r < 32; r++)
      if (reset || r == 0 || r >= NUM_REGS) cnt[r] <= '0;
      else if (issue && writes_rd && rd == 5'(r)) cnt[r] <= is_load ? SW'(LOAD_STALL) : SW'(ALU_STALL);
      else if (cnt[r] != '0) cnt[r] <= cnt[r] - SW'(1);
  always_ff @(posedge clk)
    if (reset) stall_cycles <= '0;
    else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: three differently parameterised instances share stimulus and are
// checked against a ready-time model (register usable from an absolute cycle number).
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ins_in = 32'h0;
  logic ins_valid = 1'b0;
  logic flush = 1'b0;
  logic [31:0] o_ins [3];
  logic o_v [3];
  logic o_st [3];
  logic [15:0] sc_a, sc_b;
  logic [3:0] sc_c;
  int pass = 0;
  int total = 0;
  int t = 1;
  int ready [3][32];
  int msc [3];
  int as_k [3] = '{2, 0, 2};
  int ls_k [3] = '{2, 1, 2};
  int sat_k [3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.ALU_STALL(2), .LOAD_STALL(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ins_in(ins_in), .ins_valid(ins_valid), .flush(flush),
    .ins_out(o_ins[0]), .ins_out_valid(o_v[0]), .stall(o_st[0]), .stall_cycles(sc_a));
  hazard_scoreboard_unit #(.ALU_STALL(0), .LOAD_STALL(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .ins_in(ins_in), .ins_valid(ins_valid), .flush(flush),
    .ins_out(o_ins[1]), .ins_out_valid(o_v[1]), .stall(o_st[1]), .stall_cycles(sc_b));
  hazard_scoreboard_unit #(.ALU_STALL(2), .LOAD_STALL(2), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .ins_in(ins_in), .ins_valid(ins_valid), .flush(flush),
    .ins_out(o_ins[2]), .ins_out_valid(o_v[2]), .stall(o_st[2]), .stall_cycles(sc_c));

  function automatic logic [31:0] r_ins(int rd, int a, int b);
    return {7'b0, 5'(b), 5'(a), 3'b0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] i_ins(logic [6:0] op, int rd, int a, int imm);
    return {7'b0, 5'(imm), 5'(a), 3'b0, 5'(rd), op};
  endfunction
  function automatic logic [31:0] s_ins(int a, int b);
    return {7'b0, 5'(b), 5'(a), 3'b010, 5'b0, 7'h23};
  endfunction
  function automatic int sc_of(int k);
    return k == 0 ? int'(sc_a) : k == 1 ? int'(sc_b) : int'(sc_c);
  endfunction

  // A register written at cycle w with depth N is readable from cycle w+N+1 onward.
  function automatic void model_eval(int k, output bit st, output bit iss);
    logic [6:0] op;
    int a, b;
    bit u1, u2, hz;
    op = ins_in[6:0];
    a = int'(ins_in[19:15]);
    b = int'(ins_in[24:20]);
    u1 = !(op inside {7'h37, 7'h17, 7'h6f});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    hz = ins_valid && ((u1 && a != 0 && t < ready[k][a]) || (u2 && b != 0 && t < ready[k][b]));
    st = hz && !flush && !reset;
    iss = ins_valid && !hz && !flush && !reset;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit st, iss;
      logic [6:0] op;
      int rd;
      model_eval(k, st, iss);
      op = ins_in[6:0];
      rd = int'(ins_in[11:7]);
      if (reset) begin
        for (int j = 0; j < 32; j++) ready[k][j] = 0;
        msc[k] = 0;
      end else begin
        if (st && msc[k] < sat_k[k]) msc[k]++;
        if (iss && rd != 0 && !(op inside {7'h23, 7'h63}))
          ready[k][rd] = t + (op == 7'h03 ? ls_k[k] : as_k[k]) + 1;
      end
    end
    t++;
  end

  task automatic cyc(logic [31:0] i, logic v, logic f, logic r);
    @(negedge clk);
    ins_in = i; ins_valid = v; flush = f; reset = r;
    #1;
  endtask

  task automatic do_reset();
    cyc(32'h0, 1'b0, 1'b0, 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      total++; if (o_st[k] !== 1'b0) $display("FAIL reset_stall[%0d] got %b want 0", k, o_st[k]); else pass++;
      total++; if (o_ins[k] !== 32'h13) $display("FAIL reset_out[%0d] got %h want 00000013", k, o_ins[k]); else pass++;
      total++; if (o_v[k] !== 1'b0) $display("FAIL reset_valid[%0d] got %b want 0", k, o_v[k]); else pass++;
    end
    cyc(32'h0, 1'b0, 1'b0, 1'b0);
    total++; if (sc_a !== 16'd0) $display("FAIL reset_cnt got %0d want 0", sc_a); else pass++;
    total++; if (o_ins[0] !== 32'h13) $display("FAIL idle_out got %h want 00000013", o_ins[0]); else pass++;
  endtask

  task automatic test_alu_chain();
    do_reset();
    cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b0);
    total++; if (o_v[0] !== 1'b1 || o_ins[0] !== r_ins(1, 2, 3)) $display("FAIL t1_prod got %b/%h want 1/%h", o_v[0], o_ins[0], r_ins(1, 2, 3)); else pass++;
    for (int n = 0; n < 2; n++) begin
      cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
      total++; if (o_st[0] !== 1'b1) $display("FAIL t1_stall%0d got %b want 1", n, o_st[0]); else pass++;
      total++; if (o_ins[0] !== 32'h13 || o_v[0] !== 1'b0) $display("FAIL t1_nop%0d got %h/%b want 00000013/0", n, o_ins[0], o_v[0]); else pass++;
      total++; if (o_st[1] !== 1'b0) $display("FAIL t1_fwd%0d got %b want 0", n, o_st[1]); else pass++;
    end
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0 || o_v[0] !== 1'b1) $display("FAIL t1_issue got st=%b v=%b want st=0 v=1", o_st[0], o_v[0]); else pass++;
    total++; if (o_ins[0] !== r_ins(4, 1, 5)) $display("FAIL t1_out got %h want %h", o_ins[0], r_ins(4, 1, 5)); else pass++;
    total++; if (sc_a !== 16'd2) $display("FAIL t1_cnt got %0d want 2", sc_a); else pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(i_ins(7'h03, 5, 6, 0), 1'b1, 1'b0, 1'b0);
    cyc(r_ins(7, 5, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[1] !== 1'b1) $display("FAIL t2_lstall got %b want 1", o_st[1]); else pass++;
    cyc(r_ins(7, 5, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[1] !== 1'b0 || o_v[1] !== 1'b1) $display("FAIL t2_lissue got st=%b v=%b want st=0 v=1", o_st[1], o_v[1]); else pass++;
    total++; if (sc_b !== 16'd1) $display("FAIL t2_cnt got %0d want 1", sc_b); else pass++;
    cyc(r_ins(9, 2, 3), 1'b1, 1'b0, 1'b0);
    cyc(r_ins(10, 9, 9), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[1] !== 1'b0 || o_v[1] !== 1'b1) $display("FAIL t2_alu got st=%b v=%b want st=0 v=1", o_st[1], o_v[1]); else pass++;
  endtask

  task automatic test_x0_rs2();
    do_reset();
    cyc(r_ins(0, 1, 2), 1'b1, 1'b0, 1'b0);
    cyc(r_ins(8, 0, 0), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0 || o_v[0] !== 1'b1) $display("FAIL t3_x0 got st=%b v=%b want st=0 v=1", o_st[0], o_v[0]); else pass++;
    cyc(r_ins(9, 1, 2), 1'b1, 1'b0, 1'b0);
    cyc(i_ins(7'h13, 10, 3, 9), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0) $display("FAIL t3_itype got %b want 0", o_st[0]); else pass++;
    cyc(s_ins(3, 9), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b1) $display("FAIL t3_sw got %b want 1", o_st[0]); else pass++;
    cyc(s_ins(3, 9), 1'b1, 1'b0, 1'b0);
    total++; if (o_v[0] !== 1'b1) $display("FAIL t3_sw_issue got %b want 1", o_v[0]); else pass++;
    cyc(i_ins(7'h13, 11, 11, 1), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0 || o_v[0] !== 1'b1) $display("FAIL t3_selfread got st=%b v=%b want st=0 v=1", o_st[0], o_v[0]); else pass++;
  endtask

  task automatic test_flush();
    do_reset();
    cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b0);
    cyc(r_ins(4, 1, 5), 1'b1, 1'b1, 1'b0);
    total++; if (o_st[0] !== 1'b0) $display("FAIL t4_stall got %b want 0", o_st[0]); else pass++;
    total++; if (o_ins[0] !== 32'h13 || o_v[0] !== 1'b0) $display("FAIL t4_out got %h/%b want 00000013/0", o_ins[0], o_v[0]); else pass++;
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b1) $display("FAIL t4_residual got %b want 1", o_st[0]); else pass++;
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_v[0] !== 1'b1) $display("FAIL t4_issue got %b want 1", o_v[0]); else pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b0);
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b1) $display("FAIL t5_pre got %b want 1", o_st[0]); else pass++;
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b1);
    total++; if (o_st[0] !== 1'b0 || o_ins[0] !== 32'h13) $display("FAIL t5_rst got st=%b out=%h want 0/00000013", o_st[0], o_ins[0]); else pass++;
    cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    total++; if (o_v[0] !== 1'b1 || o_ins[0] !== r_ins(4, 1, 5)) $display("FAIL t5_issue got v=%b out=%h want 1/%h", o_v[0], o_ins[0], r_ins(4, 1, 5)); else pass++;
    total++; if (sc_a !== 16'd0) $display("FAIL t5_cnt got %0d want 0", sc_a); else pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int g = 0; g < 10; g++) begin
      cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(r_ins(4, 1, 5), 1'b1, 1'b0, 1'b0);
    end
    total++; if (sc_c !== 4'hF) $display("FAIL t6_sat got %h want f", sc_c); else pass++;
    total++; if (sc_a !== 16'd20) $display("FAIL t6_wide got %0d want 20", sc_a); else pass++;
    total++; if (sc_b !== 16'd0) $display("FAIL t6_fwd got %0d want 0", sc_b); else pass++;
    cyc(r_ins(1, 2, 3), 1'b1, 1'b0, 1'b0);
    cyc(i_ins(7'h37, 5, 1, 1), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0 || o_v[0] !== 1'b1) $display("FAIL t6_lui got st=%b v=%b want st=0 v=1", o_st[0], o_v[0]); else pass++;
    cyc(i_ins(7'h6f, 6, 1, 1), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0 || o_v[0] !== 1'b1) $display("FAIL t6_jal got st=%b v=%b want st=0 v=1", o_st[0], o_v[0]); else pass++;
    cyc(i_ins(7'h17, 7, 1, 1), 1'b1, 1'b0, 1'b0);
    total++; if (o_st[0] !== 1'b0) $display("FAIL t6_auipc got %b want 0", o_st[0]); else pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    logic [31:0] ins = 32'h13;
    bit v = 1'b0, held = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit st, iss;
      if (!held) begin
        ins = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
               5'($urandom_range(0, 7)), ops[$urandom_range(0, 8)]};
        v = $urandom_range(0, 9) != 0;
      end
      cyc(ins, v, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      for (int k = 0; k < 3; k++) begin
        model_eval(k, st, iss);
        total++; if (o_st[k] !== st || o_v[k] !== iss) $display("FAIL rnd_ctl[%0d] n=%0d got st=%b v=%b want st=%b v=%b", k, n, o_st[k], o_v[k], st, iss); else pass++;
        total++; if (o_ins[k] !== (iss ? ins : 32'h13)) $display("FAIL rnd_out[%0d] n=%0d got %h want %h", k, n, o_ins[k], iss ? ins : 32'h13); else pass++;
        total++; if (sc_of(k) !== msc[k]) $display("FAIL rnd_cnt[%0d] n=%0d got %0d want %0d", k, n, sc_of(k), msc[k]); else pass++;
        if (k == 0) held = st;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_rs2();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
